// File: rtl/uart_fifo_pkg.sv
// Shared constants and Gray-code helpers for the UART async FIFO.
// Helpers work on 32-bit values; callers cast to their pointer width.
package uart_fifo_pkg;

   localparam int DEF_DATA_WIDTH  = 8;
   localparam int DEF_ADDR_WIDTH  = 4;
   localparam int DEF_SYNC_STAGES = 2;

   function automatic logic [31:0] bin2gray(input logic [31:0] b);
      return b ^ (b >> 1);
   endfunction

   function automatic logic [31:0] gray2bin(input logic [31:0] g);
      logic [31:0] b;
      b[31] = g[31];
      for (int i = 30; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

endpackage

// File: rtl/uart_sync_ff.sv
// Multi-flop synchroniser for Gray pointers crossing clock domains.
// Asynchronous active-low reset clears every stage to zero.
module uart_sync_ff #(
   parameter int WIDTH  = 5,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] stg [STAGES];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < STAGES; i++) begin
            stg[i] <= '0;
         end
      end else begin
         stg[0] <= d;
         for (int i = 1; i < STAGES; i++) begin
            stg[i] <= stg[i-1];
         end
      end
   end

   assign q = stg[STAGES-1];

endmodule

// File: rtl/uart_async_fifo.sv
// Dual-clock FWFT FIFO with Gray-pointer crossing, levels and sticky errors.
// ADDR_WIDTH must be at least 2.
module uart_async_fifo
   import uart_fifo_pkg::*;
#(
   parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
   parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
   input  logic                  wclk,
   input  logic                  rclk,
   input  logic                  rst_n,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic [ADDR_WIDTH:0]   af_th,
   input  logic                  ov_clr,
   output logic                  full,
   output logic                  almost_full,
   output logic                  overflow,
   output logic [ADDR_WIDTH:0]   wr_level,
   input  logic                  rd_en,
   input  logic [ADDR_WIDTH:0]   ae_th,
   input  logic                  ud_clr,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  empty,
   output logic                  almost_empty,
   output logic                  underflow,
   output logic [ADDR_WIDTH:0]   rd_level
);

   localparam int PW    = ADDR_WIDTH + 1;
   localparam int DEPTH = 1 << ADDR_WIDTH;
   localparam logic [PW-1:0] TOP2 = PW'(3) << (PW - 2);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic [PW-1:0] wbin, wbin_nx, wgray, wq_rgray;
   logic [PW-1:0] rbin, rbin_nx, rgray, rq_wgray;
   logic          wr_ok, rd_ok;

   // Write domain
   assign wr_ok       = wr_en & ~full;
   assign wbin_nx     = wbin + PW'(wr_ok);
   assign full        = (wgray == (wq_rgray ^ TOP2));
   assign wr_level    = wbin - PW'(gray2bin(32'(wq_rgray)));
   assign almost_full = (wr_level >= af_th);

   always_ff @(posedge wclk or negedge rst_n) begin
      if (!rst_n) begin
         wbin     <= '0;
         wgray    <= '0;
         overflow <= 1'b0;
      end else begin
         wbin  <= wbin_nx;
         wgray <= PW'(bin2gray(32'(wbin_nx)));
         if (wr_en & full) begin
            overflow <= 1'b1;
         end else if (ov_clr) begin
            overflow <= 1'b0;
         end
      end
   end

   always_ff @(posedge wclk) begin
      if (wr_ok) begin
         mem[wbin[ADDR_WIDTH-1:0]] <= wr_data;
      end
   end

   // Read domain
   assign rd_ok        = rd_en & ~empty;
   assign rbin_nx      = rbin + PW'(rd_ok);
   assign empty        = (rgray == rq_wgray);
   assign rd_level     = PW'(gray2bin(32'(rq_wgray))) - rbin;
   assign almost_empty = (rd_level <= ae_th);
   assign rd_data      = mem[rbin[ADDR_WIDTH-1:0]];

   always_ff @(posedge rclk or negedge rst_n) begin
      if (!rst_n) begin
         rbin      <= '0;
         rgray     <= '0;
         underflow <= 1'b0;
      end else begin
         rbin  <= rbin_nx;
         rgray <= PW'(bin2gray(32'(rbin_nx)));
         if (rd_en & empty) begin
            underflow <= 1'b1;
         end else if (ud_clr) begin
            underflow <= 1'b0;
         end
      end
   end

   uart_sync_ff #(
      .WIDTH  (PW),
      .STAGES (SYNC_STAGES)
   ) u_sync_r2w (
      .clk   (wclk),
      .rst_n (rst_n),
      .d     (rgray),
      .q     (wq_rgray)
   );

   uart_sync_ff #(
      .WIDTH  (PW),
      .STAGES (SYNC_STAGES)
   ) u_sync_w2r (
      .clk   (rclk),
      .rst_n (rst_n),
      .d     (wgray),
      .q     (rq_wgray)
   );

endmodule
